// File: rtl/fight_controller.sv
// fight_controller: battle turn sequencer driving the fight screen renderer
//   clk, rst_n            clock, async active-low reset
//   tick                  per-frame pulse pacing animations and HP drain
//   key_up/down/left/right/enter/back  debounced 1-cycle key pulses
//   fight_state[5:0]      1=MENU 2=CHOOSE 3=ANIM_P1 4=ANIM_P2 5=HPRED_P1 6=HPRED_P2 7=OVER
//   option_state[3:0]     cursor 1..4 on a 2x2 grid (1 2 / 3 4)
//   p1_cur_hp, p2_cur_hp  current HP of each player
//   winner[1:0]           0=none 1=P1 2=P2
//   Optional macro FIGHT_CTRL_RANDOM_AI_EN: P2 picks its damage from an 8-bit LFSR.
module fight_controller #(
    parameter logic [7:0] MAX_HP     = 8'd200,
    parameter logic [7:0] DMG_1      = 8'd20,
    parameter logic [7:0] DMG_2      = 8'd35,
    parameter logic [7:0] DMG_3      = 8'd50,
    parameter logic [7:0] DMG_4      = 8'd80,
    parameter logic [7:0] ANIM_TICKS = 8'd30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_enter,
    input  logic       key_back,
    output logic [5:0] fight_state,
    output logic [3:0] option_state,
    output logic [7:0] p1_cur_hp,
    output logic [7:0] p2_cur_hp,
    output logic [1:0] winner
);
    localparam logic [5:0] MENU     = 6'd1;
    localparam logic [5:0] CHOOSE   = 6'd2;
    localparam logic [5:0] ANIM_P1  = 6'd3;
    localparam logic [5:0] ANIM_P2  = 6'd4;
    localparam logic [5:0] HPRED_P1 = 6'd5;
    localparam logic [5:0] HPRED_P2 = 6'd6;
    localparam logic [5:0] OVER     = 6'd7;

    logic [7:0] anim_cnt, pending, hp_x;
    logic [1:0] cur, nxt_cur, p2_sel;

    function automatic logic [7:0] dmg(input logic [1:0] s);
        return s == 2'd0 ? DMG_1 : s == 2'd1 ? DMG_2 : s == 2'd2 ? DMG_3 : DMG_4;
    endfunction

`ifdef FIGHT_CTRL_RANDOM_AI_EN
    logic [7:0] lfsr;
    // Galois form of x^8+x^6+x^5+x^4+1, shifting right
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr <= 8'hA5;
        else lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
    assign p2_sel = lfsr[1:0];
`else
    assign p2_sel = 2'd0;
`endif

    // cur is the zero-based grid index: bit1 = row, bit0 = column
    always_comb begin
        cur     = option_state[1:0] - 2'd1;
        nxt_cur = (key_up | key_down) ? cur ^ 2'b10 : (key_left | key_right) ? cur ^ 2'b01 : cur;
        hp_x    = fight_state == HPRED_P1 ? p1_cur_hp : p2_cur_hp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fight_state  <= MENU;
            option_state <= 4'd1;
            p1_cur_hp    <= MAX_HP;
            p2_cur_hp    <= MAX_HP;
            winner       <= 2'd0;
            anim_cnt     <= 8'd0;
            pending      <= 8'd0;
        end else begin
            case (fight_state)
                MENU, CHOOSE: begin
                    // enter and back outrank the cursor keys even when they do nothing
                    if (key_enter) begin
                        if (fight_state == MENU && option_state == 4'd1) begin
                            fight_state <= CHOOSE;
                        end else if (fight_state == CHOOSE) begin
                            pending      <= dmg(cur);
                            anim_cnt     <= 8'd0;
                            fight_state  <= ANIM_P1;
                            option_state <= 4'd1;
                        end
                    end else if (key_back) begin
                        if (fight_state == CHOOSE) begin
                            fight_state  <= MENU;
                            option_state <= 4'd1;
                        end
                    end else begin
                        option_state <= {2'b00, nxt_cur} + 4'd1;
                    end
                end
                ANIM_P1, ANIM_P2: begin
                    if (tick) begin
                        if (anim_cnt == ANIM_TICKS - 8'd1) begin
                            anim_cnt    <= 8'd0;
                            fight_state <= fight_state == ANIM_P1 ? HPRED_P2 : HPRED_P1;
                        end else begin
                            anim_cnt <= anim_cnt + 8'd1;
                        end
                    end
                end
                HPRED_P1, HPRED_P2: begin
                    // exit conditions are evaluated every clock, draining only on tick
                    if (hp_x == 8'd0) begin
                        fight_state <= OVER;
                        winner      <= fight_state == HPRED_P2 ? 2'd1 : 2'd2;
                        pending     <= 8'd0;
                    end else if (pending == 8'd0) begin
                        fight_state <= fight_state == HPRED_P2 ? ANIM_P2 : MENU;
                        if (fight_state == HPRED_P2) pending <= dmg(p2_sel);
                    end else if (tick) begin
                        pending <= pending - 8'd1;
                        if (fight_state == HPRED_P1) p1_cur_hp <= p1_cur_hp - 8'd1;
                        else p2_cur_hp <= p2_cur_hp - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fight_controller.sv
// tb_fight_controller: randomized scoreboard bench for fight_controller
module tb_fight_controller;
    localparam logic [5:0] K_UP = 6'd1, K_DOWN = 6'd2, K_LEFT = 6'd4, K_RIGHT = 6'd8, K_ENTER = 6'd16, K_BACK = 6'd32;

    logic       clk = 0, rst_n = 0, tick = 0;
    logic       key_up = 0, key_down = 0, key_left = 0, key_right = 0, key_enter = 0, key_back = 0;
    logic [5:0] fight_state;
    logic [3:0] option_state;
    logic [7:0] p1_cur_hp, p2_cur_hp;
    logic [1:0] winner;

    fight_controller dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .key_enter(key_enter), .key_back(key_back),
        .fight_state(fight_state), .option_state(option_state),
        .p1_cur_hp(p1_cur_hp), .p2_cur_hp(p2_cur_hp), .winner(winner)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [27:0] q[$];
    int DMG[4] = '{20, 35, 50, 80};

    // game model: plain integers, cursor held as row/column
    int m_state, m_opt, m_hp1, m_hp2, m_win, m_anim, m_pend, m_lfsr;

    task automatic model_reset();
        m_state = 1; m_opt = 1; m_hp1 = 200; m_hp2 = 200; m_win = 0; m_anim = 0; m_pend = 0; m_lfsr = 'hA5;
    endtask

    task automatic model_step(input logic [5:0] k, input logic t);
        int ns, no, r, c, hp, p2d;
        ns = m_state;
        no = m_opt;
`ifdef FIGHT_CTRL_RANDOM_AI_EN
        p2d = DMG[m_lfsr % 4];
`else
        p2d = DMG[0];
`endif
        if (m_state <= 2) begin
            r = (m_opt - 1) / 2;
            c = (m_opt - 1) % 2;
            if (k[4]) begin
                if (m_state == 2) begin m_pend = DMG[m_opt - 1]; m_anim = 0; ns = 3; end
                else if (m_opt == 1) ns = 2;
            end else if (k[5]) begin
                if (m_state == 2) ns = 1;
            end else if (k[0] || k[1]) r = 1 - r;
            else if (k[2] || k[3]) c = 1 - c;
            no = (ns != m_state) ? 1 : 2 * r + c + 1;
        end else if (m_state <= 4) begin
            if (t) begin
                m_anim++;
                if (m_anim == 30) begin m_anim = 0; ns = (m_state == 3) ? 6 : 5; end
            end
        end else if (m_state <= 6) begin
            hp = (m_state == 5) ? m_hp1 : m_hp2;
            if (hp == 0) begin ns = 7; m_win = (m_state == 6) ? 1 : 2; m_pend = 0; end
            else if (m_pend == 0) begin
                if (m_state == 6) begin ns = 4; m_pend = p2d; end else ns = 1;
            end else if (t) begin
                m_pend--;
                if (m_state == 5) m_hp1--; else m_hp2--;
            end
        end
        m_state = ns;
        m_opt = no;
        m_lfsr = (m_lfsr / 2) ^ ((m_lfsr % 2 == 1) ? 'hB8 : 0);
        q.push_back({6'(m_state), 4'(m_opt), 8'(m_hp1), 8'(m_hp2), 2'(m_win)});
    endtask

    // one clock of stimulus, applied at the falling edge
    task automatic cyc(input logic [5:0] k, input logic t);
        @(negedge clk);
        {key_back, key_enter, key_right, key_left, key_down, key_up} = k;
        tick = t;
        model_step(k, t);
    endtask

    always @(posedge clk) begin
        logic [27:0] e, got;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            got = {fight_state, option_state, p1_cur_hp, p2_cur_hp, winner};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL cycle t=%0t got st=%0d opt=%0d hp1=%0d hp2=%0d win=%0d, want st=%0d opt=%0d hp1=%0d hp2=%0d win=%0d",
                         $time, got[27:22], got[21:18], got[17:10], got[9:2], got[1:0],
                         e[27:22], e[21:18], e[17:10], e[9:2], e[1:0]);
            end
        end
    end

    task automatic check_reset(input string name);
        checks++;
        if ({fight_state, option_state, p1_cur_hp, p2_cur_hp, winner} !== {6'd1, 4'd1, 8'd200, 8'd200, 2'd0}) begin
            errors++;
            $display("FAIL %s got st=%0d opt=%0d hp1=%0d hp2=%0d win=%0d, want 1 1 200 200 0",
                     name, fight_state, option_state, p1_cur_hp, p2_cur_hp, winner);
        end
    endtask

    // assert reset between edges and check it lands before the next clock
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 0;
        q.delete();
        {key_back, key_enter, key_right, key_left, key_down, key_up} = 6'd0;
        tick = 0;
        #1;
        check_reset("async_reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    // run through animation and drain phases until the game is back in MENU/CHOOSE or over
    task automatic advance();
        for (int i = 0; i < 4000 && m_state > 2 && m_state < 7; i++)
            cyc(($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0, 1'($urandom));
    endtask

    task automatic turn(input int opt);
        cyc(K_ENTER, 1'($urandom));
        if (opt == 2 || opt == 4) cyc(K_RIGHT, 1'($urandom));
        if (opt >= 3) cyc(K_DOWN, 1'($urandom));
        cyc(K_ENTER, 1'($urandom));
        advance();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        #1;
        check_reset("power_on_reset");
        // cursor moves, including a simultaneous up+left
        cyc(K_RIGHT, 0);
        cyc(K_DOWN, 1);
        cyc(K_LEFT, 0);
        cyc(K_UP | K_LEFT, 1);
        cyc(K_ENTER | K_BACK | K_DOWN, 0);
        // P1 hits with option 3, P2 counters, back to MENU
        cyc(K_BACK, 0);
        turn(3);
        // back out of CHOOSE with the cursor on option 4
        cyc(K_ENTER, 0);
        cyc(K_RIGHT, 1);
        cyc(K_DOWN, 0);
        cyc(K_BACK, 1);
        // bring P2 down then knock out
        turn(4);
        turn(1);
        turn(1);
        turn(4);
        for (int i = 0; i < 60; i++) cyc(6'($urandom), 1'($urandom));
        // reset in the middle of a drain
        do_reset();
        cyc(K_ENTER, 0);
        cyc(K_RIGHT, 0);
        cyc(K_ENTER, 0);
        for (int i = 0; i < 2000 && !(m_state == 6 && m_pend < 10); i++) cyc(6'd0, 1'($urandom));
        do_reset();
        // free-running random games
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 6000 && m_state != 7; i++)
                cyc(($urandom_range(0, 2) == 0) ? K_ENTER : 6'($urandom) & 6'($urandom), 1'($urandom));
            do_reset();
        end
        cyc(6'd0, 0);
        @(posedge clk);
        #5;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue got %0d pending entries, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
